// File: rtl/if_fetch.sv
// Instruction-fetch stage: PC, single-outstanding imem requests, 2-entry {pc, inst} buffer to decode.
// Optional IF_MISALIGN_CHK_EN: misaligned redirect targets raise sticky fetch_err and halt fetching.
module if_fetch #(
  parameter logic [31:0] RESET_PC  = 32'h0000_0000,
  parameter int          BUF_DEPTH = 2
) (
  input  logic        clk,
  input  logic        rst,
  output logic        imem_req,
  output logic [31:0] imem_addr,
  input  logic        imem_ready,
  input  logic        imem_rvalid,
  input  logic [31:0] imem_rdata,
  output logic        inst_valid,
  output logic [31:0] inst,
  output logic [31:0] inst_pc,
  input  logic        inst_ready,
  input  logic        redirect_valid,
  input  logic [3:0]  redirect_npcop,
  input  logic [31:0] redirect_pc,
  input  logic [25:0] redirect_imm,
  input  logic [31:0] redirect_rs,
  output logic        fetch_err,
  output logic [1:0]  dbg_state_o
);

  typedef enum logic [1:0] {S_REQ = 2'd0, S_WAIT = 2'd1, S_DROP = 2'd2} state_t;

  localparam logic [1:0] BUF_FULL = 2'(BUF_DEPTH);

  state_t      state_q, state_d;
  logic [31:0] pc_q, pc_d, req_pc_q, req_pc_d;
  logic [31:0] head_inst_q, head_inst_d, head_pc_q, head_pc_d;
  logic [31:0] tail_inst_q, tail_inst_d, tail_pc_q, tail_pc_d;
  logic [1:0]  count_q, count_d;
  logic        run_q;
  logic [31:0] p4, target, target_a;
  logic        halt, accept, push, pop;

  always_comb begin
    p4 = redirect_pc + 32'd4;
    case (redirect_npcop)
      4'd1:       target = p4 + {{14{redirect_imm[15]}}, redirect_imm[15:0], 2'b00};
      4'd2:       target = {p4[31:28], redirect_imm, 2'b00};
      4'd3, 4'd4: target = redirect_rs;
      default:    target = p4;
    endcase
  end

`ifdef IF_MISALIGN_CHK_EN
  logic err_q, err_d;
  assign halt      = err_q;
  assign fetch_err = err_q;
  assign target_a  = target;

  always_comb begin
    err_d = err_q;
    if (redirect_valid && (target[1:0] != 2'b00)) err_d = 1'b1;
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) err_q <= 1'b0;
    else     err_q <= err_d;
  end
`else
  assign halt      = 1'b0;
  assign fetch_err = 1'b0;
  assign target_a  = target & 32'hFFFF_FFFC;
`endif

  // Credit: S_WAIT is the only state with a request in flight, so in S_REQ outstanding is 0.
  assign imem_req    = (state_q == S_REQ) && run_q && !halt && (count_q < BUF_FULL);
  assign accept      = imem_req && imem_ready;
  assign imem_addr   = pc_q;
  assign inst_valid  = (count_q != 2'd0);
  assign inst        = head_inst_q;
  assign inst_pc     = head_pc_q;
  assign dbg_state_o = state_q;
  assign pop         = inst_valid && inst_ready;

  always_comb begin
    state_d     = state_q;
    pc_d        = pc_q;
    req_pc_d    = req_pc_q;
    count_d     = count_q;
    head_inst_d = head_inst_q;
    head_pc_d   = head_pc_q;
    tail_inst_d = tail_inst_q;
    tail_pc_d   = tail_pc_q;
    push        = 1'b0;

    case (state_q)
      S_REQ: begin
        if (accept) begin
          req_pc_d = pc_q;
          pc_d     = pc_q + 32'd4;
          state_d  = S_WAIT;
        end
      end
      S_WAIT: begin
        if (imem_rvalid) begin
          push    = !halt;
          state_d = S_REQ;
        end
      end
      S_DROP:  if (imem_rvalid) state_d = S_REQ;
      default: state_d = S_REQ;
    endcase

    if (redirect_valid) begin
      // Redirect wins over push and pop; a request already accepted must have its response dropped.
      pc_d    = target_a;
      count_d = 2'd0;
      if ((state_q == S_REQ) && accept)              state_d = S_DROP;
      else if ((state_q == S_WAIT) && !imem_rvalid) state_d = S_DROP;
    end else if (push && !pop) begin
      if (count_q == 2'd0) begin
        head_inst_d = imem_rdata;
        head_pc_d   = req_pc_q;
      end else begin
        tail_inst_d = imem_rdata;
        tail_pc_d   = req_pc_q;
      end
      count_d = count_q + 2'd1;
    end else if (!push && pop) begin
      if (count_q == 2'd2) begin
        head_inst_d = tail_inst_q;
        head_pc_d   = tail_pc_q;
      end
      count_d = count_q - 2'd1;
    end else if (push && pop) begin
      if (count_q == 2'd1) begin
        head_inst_d = imem_rdata;
        head_pc_d   = req_pc_q;
      end else begin
        head_inst_d = tail_inst_q;
        head_pc_d   = tail_pc_q;
        tail_inst_d = imem_rdata;
        tail_pc_d   = req_pc_q;
      end
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q     <= S_REQ;
      pc_q        <= RESET_PC;
      req_pc_q    <= '0;
      count_q     <= '0;
      run_q       <= 1'b0;
      head_inst_q <= '0;
      head_pc_q   <= '0;
      tail_inst_q <= '0;
      tail_pc_q   <= '0;
    end else begin
      state_q     <= state_d;
      pc_q        <= pc_d;
      req_pc_q    <= req_pc_d;
      count_q     <= count_d;
      run_q       <= 1'b1;
      head_inst_q <= head_inst_d;
      head_pc_q   <= head_pc_d;
      tail_inst_q <= tail_inst_d;
      tail_pc_q   <= tail_pc_d;
    end
  end

endmodule

// File: tb/tb_if_fetch.sv
// Bench for if_fetch: memory responder, scoreboard of expected {pc, inst} pairs, scenario tasks.
// Handshakes: a request transfers on an edge where imem_req & imem_ready; decode pops on inst_valid & inst_ready.
module tb_if_fetch;
  logic        clk = 1'b0;
  logic        rst;
  logic        imem_req, imem_ready, imem_rvalid;
  logic [31:0] imem_addr, imem_rdata;
  logic        inst_valid, inst_ready;
  logic [31:0] inst, inst_pc;
  logic        redirect_valid;
  logic [3:0]  redirect_npcop;
  logic [31:0] redirect_pc, redirect_rs;
  logic [25:0] redirect_imm;
  logic        fetch_err;
  logic [1:0]  dbg_state;

  localparam logic [1:0] S_REQ = 2'd0, S_DROP = 2'd2;

  int          checks = 0;
  int          errors = 0;
  logic [63:0] exp_q[$];
  logic [31:0] acc_q[$];
  int          extra_lat = 0;
  logic        pend = 1'b0;
  logic [31:0] pend_addr;
  int          pend_cnt;
  logic [63:0] mon_e;

  if_fetch #(.RESET_PC(32'h0000_0000), .BUF_DEPTH(2)) dut (
    .clk(clk), .rst(rst),
    .imem_req(imem_req), .imem_addr(imem_addr), .imem_ready(imem_ready),
    .imem_rvalid(imem_rvalid), .imem_rdata(imem_rdata),
    .inst_valid(inst_valid), .inst(inst), .inst_pc(inst_pc), .inst_ready(inst_ready),
    .redirect_valid(redirect_valid), .redirect_npcop(redirect_npcop), .redirect_pc(redirect_pc),
    .redirect_imm(redirect_imm), .redirect_rs(redirect_rs),
    .fetch_err(fetch_err), .dbg_state_o(dbg_state)
  );

  always #5 clk = ~clk;

  function automatic logic [31:0] mem_word(input logic [31:0] a);
    return {a[15:0] ^ 16'hC3A5, a[17:2]};
  endfunction

  // Instruction memory: responds extra_lat cycles after the minimum one-cycle latency, in order.
  always @(negedge clk) begin
    #1;
    if (rst) begin
      pend        = 1'b0;
      imem_rvalid = 1'b0;
    end else begin
      imem_rvalid = 1'b0;
      if (pend) begin
        if (pend_cnt == 0) begin
          imem_rvalid = 1'b1;
          imem_rdata  = mem_word(pend_addr);
          pend        = 1'b0;
        end else begin
          pend_cnt--;
        end
      end
      if (imem_req && imem_ready) begin
        pend      = 1'b1;
        pend_addr = imem_addr;
        pend_cnt  = extra_lat;
        acc_q.push_back(imem_addr);
      end
    end
  end

  // Scoreboard: every instruction decode consumes must be the next expected one.
  always @(negedge clk) begin
    #1;
    if (!rst && inst_valid && inst_ready && !redirect_valid) begin
      checks++;
      if (exp_q.size() == 0) begin
        errors++;
        $display("FAIL unexpected_inst pc=%h inst=%h required=none", inst_pc, inst);
      end else begin
        mon_e = exp_q.pop_front();
        if ({inst_pc, inst} !== mon_e) begin
          errors++;
          $display("FAIL inst_order got pc=%h inst=%h required pc=%h inst=%h",
                   inst_pc, inst, mon_e[63:32], mon_e[31:0]);
        end
      end
    end
  end

  function automatic void expect_fetch(input logic [31:0] a);
    exp_q.push_back({a, mem_word(a)});
  endfunction

  task automatic do_redirect(input logic [3:0] op, input logic [31:0] pc,
                             input logic [25:0] imm, input logic [31:0] rs);
    redirect_valid = 1'b1;
    redirect_npcop = op;
    redirect_pc    = pc;
    redirect_imm   = imm;
    redirect_rs    = rs;
    @(negedge clk);
    redirect_valid = 1'b0;
  endtask

  task automatic park(input logic [31:0] a);
    imem_ready = 1'b0;
    inst_ready = 1'b0;
    do_redirect(4'd3, 32'h0, 26'h0, a);
    repeat (4) @(negedge clk);
  endtask

  task automatic drain(input int budget, input string name);
    int n = 0;
    while (exp_q.size() != 0 && n < budget) begin
      @(negedge clk);
      #2;
      n++;
    end
    checks++;
    if (exp_q.size() != 0) begin
      errors++;
      $display("FAIL %s_timeout left=%0d required=0", name, exp_q.size());
      exp_q.delete();
    end
    @(negedge clk);
    inst_ready = 1'b0;
    imem_ready = 1'b0;
  endtask

  task automatic test_reset;
    rst = 1'b1; imem_ready = 1'b1; inst_ready = 1'b1; redirect_valid = 1'b0;
    redirect_npcop = 4'd0; redirect_pc = '0; redirect_imm = '0; redirect_rs = '0;
    imem_rdata = '0; imem_rvalid = 1'b0;
    repeat (2) @(negedge clk);
    #2;
    checks += 6;
    if (imem_req !== 1'b0)      begin errors++; $display("FAIL rst_req got=%b required=0", imem_req); end
    if (imem_addr !== 32'h0)    begin errors++; $display("FAIL rst_addr got=%h required=0", imem_addr); end
    if (inst_valid !== 1'b0)    begin errors++; $display("FAIL rst_valid got=%b required=0", inst_valid); end
    if (inst !== 32'h0)         begin errors++; $display("FAIL rst_inst got=%h required=0", inst); end
    if (inst_pc !== 32'h0)      begin errors++; $display("FAIL rst_inst_pc got=%h required=0", inst_pc); end
    if (fetch_err !== 1'b0)     begin errors++; $display("FAIL rst_err got=%b required=0", fetch_err); end
    acc_q.delete();
    @(negedge clk);
    rst = 1'b0;
    #2;
    checks++;
    if (imem_req !== 1'b0) begin errors++; $display("FAIL rel_req_early got=%b required=0", imem_req); end
    @(negedge clk);
    #2;
    checks += 2;
    if (imem_req !== 1'b1)   begin errors++; $display("FAIL rel_req got=%b required=1", imem_req); end
    if (imem_addr !== 32'h0) begin errors++; $display("FAIL rel_addr got=%h required=0", imem_addr); end
  endtask

  task automatic test_stream;
    logic [31:0] e;
    for (int i = 0; i < 3; i++) expect_fetch(32'(i * 4));
    drain(60, "stream");
    for (int i = 0; i < 3; i++) begin
      e = 32'(i * 4);
      checks++;
      if (i >= acc_q.size() || acc_q[i] !== e) begin
        errors++;
        $display("FAIL stream_addr%0d got=%h required=%h", i, (i < acc_q.size()) ? acc_q[i] : 32'hx, e);
      end
    end
  endtask

  task automatic test_backpressure;
    park(32'h0);
    acc_q.delete();
    expect_fetch(32'h0);
    expect_fetch(32'h4);
    imem_ready = 1'b1;
    repeat (12) @(negedge clk);
    #2;
    checks += 5;
    if (inst_valid !== 1'b1)        begin errors++; $display("FAIL bp_valid got=%b required=1", inst_valid); end
    if (imem_req !== 1'b0)          begin errors++; $display("FAIL bp_req got=%b required=0", imem_req); end
    if (inst_pc !== 32'h0)          begin errors++; $display("FAIL bp_head_pc got=%h required=0", inst_pc); end
    if (inst !== mem_word(32'h0))   begin errors++; $display("FAIL bp_head_inst got=%h required=%h", inst, mem_word(32'h0)); end
    if (acc_q.size() !== 2)         begin errors++; $display("FAIL bp_req_count got=%0d required=2", acc_q.size()); end
    expect_fetch(32'h8);
    acc_q.delete();
    @(negedge clk);
    inst_ready = 1'b1;
    drain(40, "bp");
    checks++;
    if (acc_q.size() == 0 || acc_q[0] !== 32'h8) begin
      errors++; $display("FAIL bp_resume_addr got=%h required=8", (acc_q.size() != 0) ? acc_q[0] : 32'hx);
    end
  endtask

  task automatic test_branch_drop;
    park(32'h8000);
    acc_q.delete();
    extra_lat = 1;
    imem_ready = 1'b1;
    @(negedge clk);
    do_redirect(4'd1, 32'h0000_0100, 26'h000_FFFE, 32'h0);
    #2;
    checks += 3;
    if (imem_addr !== 32'h0FC)   begin errors++; $display("FAIL br_addr got=%h required=000000fc", imem_addr); end
    if (dbg_state !== S_DROP)    begin errors++; $display("FAIL br_state got=%0d required=%0d", dbg_state, S_DROP); end
    if (inst_valid !== 1'b0)     begin errors++; $display("FAIL br_valid got=%b required=0", inst_valid); end
    expect_fetch(32'h0FC);
    @(negedge clk);
    inst_ready = 1'b1;
    drain(40, "branch");
    extra_lat = 0;
    checks++;
    if (acc_q.size() < 2 || acc_q[1] !== 32'h0FC) begin
      errors++; $display("FAIL br_next_req got=%h required=000000fc", (acc_q.size() > 1) ? acc_q[1] : 32'hx);
    end
  endtask

  task automatic test_redirect_accept;
    park(32'h8000);
    acc_q.delete();
    imem_ready = 1'b1;
    do_redirect(4'd3, 32'h0, 26'h0, 32'h3000);
    #2;
    checks += 3;
    if (dbg_state !== S_DROP)  begin errors++; $display("FAIL acc_state got=%0d required=%0d", dbg_state, S_DROP); end
    if (imem_addr !== 32'h3000) begin errors++; $display("FAIL acc_addr got=%h required=00003000", imem_addr); end
    if (imem_req !== 1'b0)     begin errors++; $display("FAIL acc_req got=%b required=0", imem_req); end
    expect_fetch(32'h3000);
    @(negedge clk);
    inst_ready = 1'b1;
    drain(40, "accept");
    checks++;
    if (acc_q.size() < 2 || acc_q[1] !== 32'h3000) begin
      errors++; $display("FAIL acc_next_req got=%h required=00003000", (acc_q.size() > 1) ? acc_q[1] : 32'hx);
    end
  endtask

  task automatic test_redirect_rvalid;
    park(32'h8000);
    acc_q.delete();
    imem_ready = 1'b1;
    @(negedge clk);
    do_redirect(4'd4, 32'h0, 26'h0, 32'h6000);
    #2;
    checks += 2;
    if (dbg_state !== S_REQ)    begin errors++; $display("FAIL rv_state got=%0d required=%0d", dbg_state, S_REQ); end
    if (imem_addr !== 32'h6000) begin errors++; $display("FAIL rv_addr got=%h required=00006000", imem_addr); end
    expect_fetch(32'h6000);
    @(negedge clk);
    inst_ready = 1'b1;
    drain(40, "rvalid");
  endtask

  task automatic test_targets;
    logic [3:0]  op[8]  = '{4'd2, 4'd3, 4'd4, 4'd0, 4'd7, 4'd1, 4'd1, 4'd2};
    logic [31:0] pc[8]  = '{32'h1000_0000, 32'h0, 32'h0, 32'h300, 32'h400, 32'h200, 32'hFFFF_FFF0, 32'hA000_0000};
    logic [25:0] imm[8] = '{26'h40, 26'h0, 26'h0, 26'h0, 26'h0, 26'h10, 26'h4, 26'h3FF_FFFF};
    logic [31:0] rs[8]  = '{32'h0, 32'h2000, 32'h5554, 32'h0, 32'h0, 32'h0, 32'h0, 32'h0};
    logic [31:0] ex[8]  = '{32'h1000_0100, 32'h2000, 32'h5554, 32'h304, 32'h404, 32'h244, 32'h4, 32'hAFFF_FFFC};
    park(32'h8000);
    for (int i = 0; i < 8; i++) begin
      do_redirect(op[i], pc[i], imm[i], rs[i]);
      #2;
      checks += 2;
      if (imem_addr !== ex[i]) begin errors++; $display("FAIL target%0d got=%h required=%h", i, imem_addr, ex[i]); end
      if (imem_req !== 1'b1)   begin errors++; $display("FAIL target%0d_req got=%b required=1", i, imem_req); end
      @(negedge clk);
    end
    expect_fetch(32'hAFFF_FFFC);
    imem_ready = 1'b1;
    inst_ready = 1'b1;
    drain(40, "targets");
  endtask

  task automatic test_back_to_back;
    int          n = 0;
    logic        hold = 1'b0;
    logic [31:0] hold_addr = '0;
    park(32'h4000);
    for (int i = 0; i < 10; i++) expect_fetch(32'h4000 + 32'(i * 4));
    while (exp_q.size() != 0 && n < 400) begin
      inst_ready = 1'($urandom_range(0, 1));
      imem_ready = 1'($urandom_range(0, 1));
      extra_lat  = $urandom_range(0, 2);
      #2;
      if (hold) begin
        checks++;
        if (imem_addr !== hold_addr) begin errors++; $display("FAIL addr_stable got=%h required=%h", imem_addr, hold_addr); end
      end
      hold      = imem_req && !imem_ready;
      hold_addr = imem_addr;
      @(negedge clk);
      n++;
    end
    checks++;
    if (exp_q.size() != 0) begin
      errors++; $display("FAIL b2b_timeout left=%0d required=0", exp_q.size());
      exp_q.delete();
    end
    inst_ready = 1'b0;
    imem_ready = 1'b0;
    extra_lat  = 0;
    @(negedge clk);
  endtask

  task automatic test_misalign;
    park(32'h8000);
    imem_ready = 1'b1;
    @(negedge clk);
    do_redirect(4'd3, 32'h0, 26'h0, 32'h2002);
`ifdef IF_MISALIGN_CHK_EN
    inst_ready = 1'b1;
    for (int i = 0; i < 6; i++) begin
      #2;
      checks += 3;
      if (fetch_err !== 1'b1)  begin errors++; $display("FAIL mis_err%0d got=%b required=1", i, fetch_err); end
      if (imem_req !== 1'b0)   begin errors++; $display("FAIL mis_req%0d got=%b required=0", i, imem_req); end
      if (inst_valid !== 1'b0) begin errors++; $display("FAIL mis_valid%0d got=%b required=0", i, inst_valid); end
      @(negedge clk);
    end
    imem_ready = 1'b0;
    inst_ready = 1'b0;
    rst = 1'b1;
    #2;
    checks++;
    if (fetch_err !== 1'b0) begin errors++; $display("FAIL mis_rst_err got=%b required=0", fetch_err); end
    @(negedge clk);
    rst = 1'b0;
    @(negedge clk);
`else
    #2;
    checks += 2;
    if (imem_addr !== 32'h2000) begin errors++; $display("FAIL mis_addr got=%h required=00002000", imem_addr); end
    if (fetch_err !== 1'b0)     begin errors++; $display("FAIL mis_err got=%b required=0", fetch_err); end
    expect_fetch(32'h2000);
    @(negedge clk);
    inst_ready = 1'b1;
    drain(40, "misalign");
`endif
  endtask

  initial begin
    test_reset();
    test_stream();
    test_backpressure();
    test_branch_drop();
    test_redirect_accept();
    test_redirect_rvalid();
    test_targets();
    test_back_to_back();
    test_misalign();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/if_fetch.md
Name: if_fetch

Overview:
- Instruction-fetch stage that feeds the instruction decoder and control unit: holds the PC, issues fetch requests to instruction memory, and presents {pc, instruction} to decode through a 2-entry buffer.
- Consumes the control unit's 4-bit next-PC operation (PLUS4/BRANCH/JUMP/JR/JALR encoding) on a redirect, computes the target, and flushes stale fetches.

Parameters:
- RESET_PC, 32'h0000_0000, PC of the first fetch after reset.
- BUF_DEPTH, 2, instruction-buffer entries; fixed at 2, other values unsupported.

Ports:
- clk  in  1  clock, all state updates on rising edge.
- rst  in  1  reset, asynchronous, active-high.
- imem_req  out  1  fetch request valid.
- imem_addr  out  32  fetch address; word aligned; stable while imem_req=1 and imem_ready=0.
- imem_ready  in  1  memory accepts the request this cycle.
- imem_rvalid  in  1  read data valid; at least 1 cycle after acceptance, in order.
- imem_rdata  in  32  instruction word.
- inst_valid  out  1  buffer head valid.
- inst  out  32  buffer head instruction; Op = inst[31:26], Funct = inst[5:0].
- inst_pc  out  32  PC of the buffer head.
- inst_ready  in  1  decode consumes the head this cycle.
- redirect_valid  in  1  apply a control-flow change this cycle.
- redirect_npcop  in  4  0=PLUS4, 1=BRANCH, 2=JUMP, 3=JR, 4=JALR; others treated as PLUS4.
- redirect_pc  in  32  PC of the redirecting instruction.
- redirect_imm  in  26  instr[25:0]; BRANCH uses [15:0].
- redirect_rs  in  32  register value for JR/JALR.
- fetch_err  out  1  sticky misaligned-target flag (see Optional Feature).

Behaviour:
- Reset (async, rst=1): imem_req=0, imem_addr=RESET_PC, inst_valid=0, inst=0, inst_pc=0, fetch_err=0, buffer empty, state S_REQ. First imem_req=1 in the first cycle after rst deasserts.
- Target arithmetic (32-bit, wraps mod 2^32), p4 = redirect_pc+4:
  - PLUS4: p4.
  - BRANCH: p4 + (sign_extend(imm[15:0]) << 2).
  - JUMP: {p4[31:28], imm[25:0], 2'b00}.
  - JR/JALR: redirect_rs.
- No delay slot.
- Credit rule: a request may issue only if buffer_count + outstanding < 2, where outstanding is 0 or 1. At most one request is in flight.
- S_REQ:
  - imem_req=1 when credit is available; otherwise imem_req=0 and stay in S_REQ.
  - On imem_ready=1: latch req_pc=imem_addr, imem_addr <= imem_addr+4, go to S_WAIT.
- S_WAIT:
  - imem_req=0.
  - On imem_rvalid: push {req_pc, imem_rdata}, go to S_REQ.
- S_DROP:
  - imem_req=0.
  - On imem_rvalid: discard the data, go to S_REQ.
- Redirect (redirect_valid=1, sampled at the edge):
  - imem_addr <= target; buffer flushed; inst_valid=0 next cycle.
  - Any pop in the same cycle is ignored.
  - S_REQ with imem_ready=0: the pending request is abandoned; the new address is presented next cycle.
  - S_REQ with imem_ready=1 (accepted same cycle): go to S_DROP.
  - S_WAIT with no rvalid: go to S_DROP.
  - S_WAIT with rvalid same cycle: data discarded, go to S_REQ.
  - S_DROP: stay in S_DROP.
- Buffer:
  - Push and pop in the same cycle are allowed; count is unchanged.
  - Pop when inst_valid & inst_ready; inst/inst_pc are the head registers.
  - Push into empty buffer: inst_valid=1 the next cycle (fetch latency = request accept + rvalid + 1).
  - Full: no new request (credit rule); overflow is impossible.
  - Pop from empty: ignored.
- inst/inst_pc keep their last value when inst_valid=0.

Optional Feature:
- Macro IF_MISALIGN_CHK_EN.
- Defined: a redirect target with target[1:0] != 0 sets fetch_err=1 (sticky until rst). imem_req is forced to 0 permanently; the buffer is flushed; a response already in flight is discarded.
- Undefined: target[1:0] is forced to 2'b00 and fetch_err is tied to 0.

Test Plan:
- Reset release, imem_ready=1, 1-cycle rvalid, inst_ready=1 → imem_addr sequence 0,4,8; inst_pc 0,4,8 in order; inst matches rdata.
- inst_ready=0 held → exactly 2 instructions buffered, imem_req=0 thereafter; inst_ready=1 → drains pc 0 then 4, fetch resumes at 8.
- BRANCH: redirect_pc=0x100, imm=16'hFFFE → next imem_addr=0x0FC; outstanding response for the old address dropped; first inst_pc after redirect=0x0FC.
- JUMP: redirect_pc=0x1000_0000, imm=26'h0000040 → target 0x1000_0100. JR: rs=0x2000 → 0x2000.
- Redirect in the same cycle as imem_ready=1 → S_DROP; the following rvalid data never appears on inst; next request uses the target address.
- IF_MISALIGN_CHK_EN defined, JR with rs=0x2002 → fetch_err=1, imem_req=0 until rst. Undefined → imem_addr=0x2000.
